// File: rtl/axi_qos_txn_arbiter_if.sv
// Arbiter request/grant bundle for one slave channel.
// master: requesting side drives req/qos/accept/done; slave: arbiter drives grant/busy.
interface axi_qos_txn_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int QOS_WIDTH = 4
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*QOS_WIDTH-1:0] qos;
   logic                         accept;
   logic                         done;
   logic [NUM_REQ-1:0]           grant;
   logic                         grant_valid;
   logic [IDX_W-1:0]             grant_idx;
   logic                         busy;

   modport master (
      output req, qos, accept, done,
      input  grant, grant_valid, grant_idx, busy
   );

   modport slave (
      input  req, qos, accept, done,
      output grant, grant_valid, grant_idx, busy
   );
endinterface

// File: rtl/axi_qos_txn_arbiter.sv
// Transaction arbiter (FIXED / ROUND_ROBIN / QOS with age promotion).
// Ports: ACLK, ARESET (async, active-high), arb (slave modport of the bundle).
module axi_qos_txn_arbiter #(
   parameter int    NUM_REQ          = 2,
   parameter int    QOS_WIDTH        = 4,
   parameter int    AGE_WIDTH        = 4,
   parameter int    AGE_THRESHOLD    = 8,
   parameter string ARBITRATION_MODE = "QOS"
) (
   input  logic ACLK,
   input  logic ARESET,
   axi_qos_txn_arbiter_if.slave arb
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // 0 = FIXED, 1 = ROUND_ROBIN (also the fallback), 2 = QOS
   localparam int MODE = (ARBITRATION_MODE == "FIXED") ? 0 :
                         (ARBITRATION_MODE == "QOS")   ? 2 : 1;
   localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;
   localparam logic [AGE_WIDTH-1:0] AGE_THR  = AGE_WIDTH'(AGE_THRESHOLD);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q;
   logic [IDX_W-1:0]     idx_q, last_q, win;
   logic [AGE_WIDTH-1:0] age_q [NUM_REQ];
   logic                 arb_ev, acc_ev, to_idle;

   assign arb_ev  = (state_q == IDLE) && (|arb.req);
   assign acc_ev  = (state_q == GRANT) && arb.accept;
   assign to_idle = (state_q != IDLE) && (state_d == IDLE);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (|arb.req) state_d = GRANT;
         GRANT: begin
            if (arb.accept)            state_d = arb.done ? IDLE : BUSY;
            else if (!arb.req[idx_q])  state_d = IDLE;
         end
         BUSY:  if (arb.done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Scan in round-robin order from last+1. The first hit wins unless a
   // later candidate beats it: lower index (FIXED) or strictly higher
   // {promoted, qos} key (QOS), so QOS ties fall back to round-robin.
   always_comb begin
      logic                 found;
      logic [QOS_WIDTH:0]   best, key;
      logic [IDX_W-1:0]     c;
      win   = '0;
      found = 1'b0;
      best  = '0;
      key   = '0;
      c     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         c   = IDX_W'((int'(last_q) + k) % NUM_REQ);
         key = {age_q[c] >= AGE_THR,
                arb.qos[int'(c)*QOS_WIDTH +: QOS_WIDTH]};
         if (arb.req[c]) begin
            if (!found
                || (MODE == 0 && c < win)
                || (MODE == 2 && key > best)) begin
               win   = c;
               best  = key;
               found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         grant_q <= '0;
         idx_q   <= '0;
         last_q  <= LAST_RST;
         for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
      end else begin
         if (arb_ev) begin
            grant_q <= NUM_REQ'(1) << win;
            idx_q   <= win;
         end else if (to_idle) begin
            grant_q <= '0;
            idx_q   <= '0;
         end
         if (acc_ev) last_q <= idx_q;
         if (MODE == 2 && arb_ev) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (IDX_W'(i) == win)
                  age_q[i] <= '0;
               else if (arb.req[i] && age_q[i] != AGE_MAX)
                  age_q[i] <= age_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      arb.grant       = grant_q;
      arb.grant_valid = |grant_q;
      arb.grant_idx   = idx_q;
      arb.busy        = (state_q == BUSY);
   end
endmodule

// File: tb/tb_axi_qos_txn_arbiter.sv
// Scoreboard bench: FIXED, ROUND_ROBIN and QOS arbiters share one stimulus.
// Expected winners/ages are queued per arbitration and compared on grant.
module tb_axi_qos_txn_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [7:0] qos;
   logic       accept;
   logic       done;

   always #5 clk = ~clk;

   axi_qos_txn_arbiter_if #(.NUM_REQ(2), .QOS_WIDTH(4)) if_fx ();
   axi_qos_txn_arbiter_if #(.NUM_REQ(2), .QOS_WIDTH(4)) if_rr ();
   axi_qos_txn_arbiter_if #(.NUM_REQ(2), .QOS_WIDTH(4)) if_qs ();

   assign if_fx.req = req;  assign if_fx.qos = qos;
   assign if_fx.accept = accept;  assign if_fx.done = done;
   assign if_rr.req = req;  assign if_rr.qos = qos;
   assign if_rr.accept = accept;  assign if_rr.done = done;
   assign if_qs.req = req;  assign if_qs.qos = qos;
   assign if_qs.accept = accept;  assign if_qs.done = done;

   axi_qos_txn_arbiter #(
      .NUM_REQ(2), .QOS_WIDTH(4), .AGE_WIDTH(4),
      .AGE_THRESHOLD(3), .ARBITRATION_MODE("FIXED")
   ) dut_fx (.ACLK(clk), .ARESET(rst), .arb(if_fx));

   axi_qos_txn_arbiter #(
      .NUM_REQ(2), .QOS_WIDTH(4), .AGE_WIDTH(4),
      .AGE_THRESHOLD(3), .ARBITRATION_MODE("ROUND_ROBIN")
   ) dut_rr (.ACLK(clk), .ARESET(rst), .arb(if_rr));

   axi_qos_txn_arbiter #(
      .NUM_REQ(2), .QOS_WIDTH(4), .AGE_WIDTH(4),
      .AGE_THRESHOLD(3), .ARBITRATION_MODE("QOS")
   ) dut_qs (.ACLK(clk), .ARESET(rst), .arb(if_qs));

   logic [1:0] g  [3];
   logic       gi [3];
   logic       gv [3];
   logic       bz [3];

   assign g[0] = if_fx.grant;  assign gi[0] = if_fx.grant_idx;
   assign gv[0] = if_fx.grant_valid;  assign bz[0] = if_fx.busy;
   assign g[1] = if_rr.grant;  assign gi[1] = if_rr.grant_idx;
   assign gv[1] = if_rr.grant_valid;  assign bz[1] = if_rr.busy;
   assign g[2] = if_qs.grant;  assign gi[2] = if_qs.grant_idx;
   assign gv[2] = if_qs.grant_valid;  assign bz[2] = if_qs.busy;

   typedef struct {
      int w [3];
      int age1;
   } exp_t;

   exp_t sb [$];
   int   vectors = 0;
   int   errors  = 0;
   string nm [3] = '{"fixed", "rr", "qos"};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int a, input int b, input int c, input int a1);
      exp_t e;
      e.w[0] = a;  e.w[1] = b;  e.w[2] = c;  e.age1 = a1;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;  qos = '0;  accept = 1'b0;  done = 1'b0;
      step();
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic await_grant(output exp_t e);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 4) begin
         step();
         lat++;
         seen = gv[0] | gv[1] | gv[2];
      end
      vectors++;
      if (!seen || lat != 1) begin
         errors++;
         $display("FAIL grant_latency: got %0d cycles (seen=%0b), need 1",
                  lat, seen);
      end
      e.w[0] = 0;  e.w[1] = 0;  e.w[2] = 0;  e.age1 = -1;
      vectors++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got grant, no expectation");
      end else begin
         e = sb.pop_front();
      end
      for (int d = 0; d < 3; d++) begin
         logic [1:0] eg;
         logic       ei;
         eg = 2'b01 << e.w[d];
         ei = e.w[d][0];
         vectors++;
         if ({gv[d], gi[d], g[d]} !== {1'b1, ei, eg}) begin
            errors++;
            $display("FAIL grant_%s: got v=%0b idx=%0d g=%b, need v=1 idx=%0d g=%b",
                     nm[d], gv[d], gi[d], g[d], ei, eg);
         end
      end
      if (e.age1 >= 0) begin
         vectors++;
         if (dut_qs.age_q[1] !== 4'(e.age1)) begin
            errors++;
            $display("FAIL age1: got %0d, need %0d", dut_qs.age_q[1], e.age1);
         end
      end
   endtask

   task automatic finish_txn(input exp_t e, input bit coincide);
      accept = 1'b1;
      done   = coincide;
      step();
      if (!coincide) begin
         for (int d = 0; d < 3; d++) begin
            logic [1:0] eg;
            eg = 2'b01 << e.w[d];
            vectors++;
            if (bz[d] !== 1'b1 || g[d] !== eg) begin
               errors++;
               $display("FAIL busy_hold_%s: got busy=%0b g=%b, need busy=1 g=%b",
                        nm[d], bz[d], g[d], eg);
            end
         end
         accept = 1'b0;
         done   = 1'b1;
         step();
      end
      accept = 1'b0;
      done   = 1'b0;
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({bz[d], gv[d], g[d]} !== 4'b0000) begin
            errors++;
            $display("FAIL release_%s: got busy=%0b v=%0b g=%b, need all 0",
                     nm[d], bz[d], gv[d], g[d]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 2'b11;  qos = 8'h5a;  accept = 1'b0;  done = 1'b0;
      #3;
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({bz[d], gv[d], gi[d], g[d]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_%s: got busy=%0b v=%0b idx=%0d g=%b, need 0",
                     nm[d], bz[d], gv[d], gi[d], g[d]);
         end
      end
      vectors++;
      if (dut_qs.age_q[0] !== 4'd0 || dut_qs.age_q[1] !== 4'd0) begin
         errors++;
         $display("FAIL reset_ages: got %0d/%0d, need 0/0",
                  dut_qs.age_q[0], dut_qs.age_q[1]);
      end
      step();
      vectors++;
      if (gv[0] | gv[1] | gv[2]) begin
         errors++;
         $display("FAIL reset_hold: grant during reset, need none");
      end
   endtask

   task automatic test_fixed_rr();
      exp_t e;
      do_reset();
      qos = '0;
      req = 2'b11;
      push(0, 0, 0, 1);
      push(0, 1, 1, 0);
      push(0, 0, 0, 1);
      push(0, 1, 1, 0);
      repeat (4) begin
         await_grant(e);
         finish_txn(e, 1'b0);
      end
   endtask

   task automatic test_qos_age();
      exp_t e;
      do_reset();
      qos = {4'd2, 4'd12};
      req = 2'b11;
      push(0, 0, 0, 1);
      push(0, 1, 0, 2);
      push(0, 0, 0, 3);
      push(0, 1, 1, 0);
      push(0, 0, 0, 1);
      repeat (5) begin
         await_grant(e);
         finish_txn(e, 1'b0);
      end
   endtask

   task automatic test_qos_tie();
      exp_t e;
      do_reset();
      qos = {4'd5, 4'd5};
      req = 2'b11;
      push(0, 0, 0, 1);
      push(0, 1, 1, 0);
      push(0, 0, 0, 1);
      for (int n = 0; n < 3; n++) begin
         await_grant(e);
         finish_txn(e, n == 1);
      end
   endtask

   task automatic test_withdraw();
      exp_t e;
      do_reset();
      qos = {4'd5, 4'd5};
      req = 2'b11;
      push(0, 0, 0, 1);
      await_grant(e);
      done = 1'b1;
      step();
      done = 1'b0;
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if (g[d] !== 2'b01 || bz[d] !== 1'b0) begin
            errors++;
            $display("FAIL done_ignored_%s: got g=%b busy=%0b, need g=01 busy=0",
                     nm[d], g[d], bz[d]);
         end
      end
      req = 2'b10;
      step();
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({gv[d], g[d]} !== 3'b000) begin
            errors++;
            $display("FAIL withdraw_%s: got v=%0b g=%b, need 0",
                     nm[d], gv[d], g[d]);
         end
      end
      req = 2'b11;
      push(0, 0, 0, 2);
      await_grant(e);
      finish_txn(e, 1'b1);
      push(0, 1, 1, 0);
      await_grant(e);
      finish_txn(e, 1'b0);
   endtask

   task automatic test_reset_busy();
      exp_t e;
      do_reset();
      qos = {4'd5, 4'd5};
      req = 2'b11;
      push(0, 0, 0, 1);
      await_grant(e);
      finish_txn(e, 1'b0);
      push(0, 1, 1, 0);
      await_grant(e);
      accept = 1'b1;
      step();
      accept = 1'b0;
      vectors++;
      if (bz[1] !== 1'b1 || g[1] !== 2'b10) begin
         errors++;
         $display("FAIL busy_before_reset: got busy=%0b g=%b, need 1/10",
                  bz[1], g[1]);
      end
      #1 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({bz[d], gv[d], gi[d], g[d]} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_%s: got busy=%0b v=%0b g=%b, need 0",
                     nm[d], bz[d], gv[d], g[d]);
         end
      end
      vectors++;
      if (dut_qs.age_q[0] !== 4'd0 || dut_qs.age_q[1] !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_ages: got %0d/%0d, need 0/0",
                  dut_qs.age_q[0], dut_qs.age_q[1]);
      end
      #1 rst = 1'b0;
      sb.delete();
      push(0, 0, 0, 1);
      await_grant(e);
      finish_txn(e, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fixed_rr();
      test_qos_age();
      test_qos_tie();
      test_withdraw();
      test_reset_busy();
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, need 0",
                  sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
